sprite_slot_ctrl: RTL
=====================

Name: sprite_slot_ctrl

Overview:
Per-frame scheduler for a pool of N_SPR sprite engines (obstacle ducks and clouds) sharing one screen.
- Owns each slot's enable and position, and scrolls active sprites left once per frame during vblank.
- Retires sprites that have left the screen and allocates free slots to spawn requests from game logic.
- Merges the engines' pixel outputs by fixed priority and flags player/sprite overlap for collision detection.

Parameters:
N_SPR, 4, number of sprite slots (2..8)
CORDW, 11, signed coordinate width
H_RES, 640, horizontal resolution; x coordinate given to a new spawn
SPR_WIDTH, 16, sprite bitmap width in pixels
SPR_SCALE, 1, log2 scale factor; on-screen width = SPR_WIDTH<<SPR_SCALE
SPR_DATAW, 3, bits per pixel

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
frame  in  1  one-cycle pulse at vblank start
spawn_req  in  1  one-cycle spawn request
spawn_y  in  CORDW  signed y of requested sprite
speed  in  4  unsigned pixels per frame of leftward scroll
spawn_ack  out  1  one-cycle pulse when a slot is allocated
spawn_drop  out  1  one-cycle pulse when a request is rejected
spr_en  out  N_SPR  per-slot enable to the sprite engines
sprx_bus  out  N_SPR*CORDW  slot i x at [i*CORDW +: CORDW], signed
spry_bus  out  N_SPR*CORDW  slot i y, same packing
spr_drawing  in  N_SPR  drawing flags from the engines
spr_pix  in  N_SPR*SPR_DATAW  pixel data from the engines, same packing
player_drawing  in  1  player sprite drawing at the current pixel
pix_out  out  SPR_DATAW  composited sprite pixel
drawing_out  out  1  any enabled sprite drawing
hit  out  1  sticky collision flag
busy  out  1  update in progress
active_cnt  out  $clog2(N_SPR+1)  number of enabled slots

Behaviour:
- Reset: state IDLE. spr_en=0. All x=0 and y=0. pend=0. pix_out=0. drawing_out=0. hit=0. spawn_ack=0. spawn_drop=0. busy=0. Reset overrides all other activity, including mid-scan.
- States:
  - IDLE: frame -> SCAN with idx=0, and hit cleared in the same cycle.
  - SCAN: processes one slot per cycle. When idx==N_SPR-1 -> SPAWN.
  - SPAWN: one cycle, then -> IDLE.
- busy=1 in SCAN and SPAWN. A frame pulse received while busy is ignored.
- SCAN, slot idx with spr_en set:
  - x_new = x - speed, computed at CORDW+1 bits signed.
  - If x_new <= -(SPR_WIDTH<<SPR_SCALE), clear spr_en[idx]. x is left unchanged.
  - Otherwise x <= x_new.
  - speed=0 leaves positions unchanged. Disabled slots are untouched.
- Spawn latch:
  - spawn_req with pend=0, in any state: latch spawn_y and set pend=1.
  - spawn_req with pend=1: the request is discarded and spawn_drop pulses the next cycle.
  - spawn_req in the same cycle as the SPAWN that clears pend: the new request is latched (pend stays 1).
- SPAWN allocation:
  - If pend=1 and a free slot exists, the lowest-index free slot gets en=1, x=H_RES, y=latched y. pend is cleared and spawn_ack pulses the next cycle.
  - Slots freed in this frame's SCAN are eligible.
  - If no slot is free, pend stays 1 and the request is retried next frame.
- All slot outputs are registered. Positions change only in SCAN/SPAWN, so within vblank when frame is aligned to vblank.
- Compositor, 1-cycle registered latency:
  - pix_out = spr_pix of the lowest index i with spr_drawing[i] & spr_en[i]; 0 if none.
  - drawing_out = |(spr_drawing & spr_en).
- hit is set when player_drawing & |(spr_drawing & spr_en). If set and clear coincide, set wins.
- active_cnt = popcount(spr_en), registered.

Decomposition:
- Shared package sprite_pkg:
  - state encoding IDLE/SCAN/SPAWN
  - CORDW and SPR_DATAW defaults
  - a function that computes the on-screen sprite width
- One sub-module, sprite_pix_mux: the parameterised priority compositor plus the hit logic.

Test Plan:
- Reset, then spawn_req with spawn_y=100 and frame -> spawn_ack in SPAWN; spr_en=0001; slot0 x=640, y=100; busy high for N_SPR+1 cycles.
- Slot0 at x=-20, speed=15, frame -> x_new=-35 <= -32, so spr_en[0] clears; a pending request in the same frame reuses slot0 with x=640.
- All 4 slots enabled, spawn_req, two frames -> no ack and pend held; a second spawn_req -> spawn_drop pulse; after slot2 retires, the next frame acks into slot2.
- spr_drawing=0110 with pix 3 on slot1 and 5 on slot2 -> pix_out=3 and drawing_out=1 one cycle later; with spr_en[1]=0 -> pix_out=5.
- player_drawing with spr_drawing[3] for one cycle -> hit=1 held until the next accepted frame; a coincident set and clear -> hit stays 1.
- frame pulse during SCAN -> ignored; rst asserted mid-SCAN -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite slot scheduler: FSM encoding, default widths
// and the on-screen sprite width helper.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SPAWN
    } state_t;

    localparam int CORDW_DEF     = 11;
    localparam int SPR_DATAW_DEF = 3;

    function automatic int spr_screen_w(input int width, input int scale);
        return width << scale;
    endfunction

endpackage

// File: rtl/sprite_slot_ctrl_if.sv
// Game-logic side of the sprite scheduler: frame strobe, scroll speed and the
// spawn request/acknowledge handshake.
interface sprite_slot_ctrl_if
    import sprite_pkg::*;
#(
    parameter int CORDW = CORDW_DEF
) ();

    logic                    frame;
    logic                    spawn_req;
    logic signed [CORDW-1:0] spawn_y;
    logic [3:0]              speed;
    logic                    spawn_ack;
    logic                    spawn_drop;

    modport master (
        output frame, spawn_req, spawn_y, speed,
        input  spawn_ack, spawn_drop
    );

    modport slave (
        input  frame, spawn_req, spawn_y, speed,
        output spawn_ack, spawn_drop
    );

endinterface

// File: rtl/sprite_pix_mux.sv
// Fixed-priority sprite pixel compositor (lowest slot wins) with a sticky
// player/sprite collision flag.
module sprite_pix_mux
    import sprite_pkg::*;
#(
    parameter int N_SPR     = 4,
    parameter int SPR_DATAW = SPR_DATAW_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SPR-1:0]           spr_en,
    input  logic [N_SPR-1:0]           spr_drawing,
    input  logic [N_SPR*SPR_DATAW-1:0] spr_pix,
    input  logic                       player_drawing,
    input  logic                       hit_clr,
    output logic [SPR_DATAW-1:0]       pix_out,
    output logic                       drawing_out,
    output logic                       hit
);

    logic [N_SPR-1:0]     act;
    logic [SPR_DATAW-1:0] pix_sel;

    assign act = spr_drawing & spr_en;

    // Walk from the highest slot down so the lowest active slot is written last.
    always_comb begin
        pix_sel = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (act[i]) pix_sel = spr_pix[i*SPR_DATAW +: SPR_DATAW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_out     <= '0;
            drawing_out <= 1'b0;
            hit         <= 1'b0;
        end else begin
            pix_out     <= pix_sel;
            drawing_out <= |act;
            // A collision in the same cycle as the frame clear must not be lost.
            if (player_drawing && |act) hit <= 1'b1;
            else if (hit_clr)           hit <= 1'b0;
        end
    end

endmodule

// File: rtl/sprite_slot_ctrl.sv
// Per-frame sprite slot scheduler: scrolls and retires active slots one per
// cycle after each frame pulse, then allocates the lowest free slot to a pending spawn.
module sprite_slot_ctrl
    import sprite_pkg::*;
#(
    parameter int N_SPR     = 4,
    parameter int CORDW     = CORDW_DEF,
    parameter int H_RES     = 640,
    parameter int SPR_WIDTH = 16,
    parameter int SPR_SCALE = 1,
    parameter int SPR_DATAW = SPR_DATAW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    sprite_slot_ctrl_if.slave            ctl,
    output logic [N_SPR-1:0]             spr_en,
    output logic [N_SPR*CORDW-1:0]       sprx_bus,
    output logic [N_SPR*CORDW-1:0]       spry_bus,
    input  logic [N_SPR-1:0]             spr_drawing,
    input  logic [N_SPR*SPR_DATAW-1:0]   spr_pix,
    input  logic                         player_drawing,
    output logic [SPR_DATAW-1:0]         pix_out,
    output logic                         drawing_out,
    output logic                         hit,
    output logic                         busy,
    output logic [$clog2(N_SPR+1)-1:0]   active_cnt
);

    localparam int SCR_W = spr_screen_w(SPR_WIDTH, SPR_SCALE);
    localparam int IDXW  = $clog2(N_SPR);
    localparam int CNTW  = $clog2(N_SPR + 1);
    localparam logic [IDXW-1:0]         LAST_IDX = IDXW'(N_SPR - 1);
    localparam logic signed [CORDW:0]   X_LIM    = -(CORDW+1)'(SCR_W);

    state_t                  state, state_nxt;
    logic [IDXW-1:0]         idx;
    logic signed [CORDW-1:0] pos_x [N_SPR];
    logic signed [CORDW-1:0] pos_y [N_SPR];
    logic                    pend;
    logic signed [CORDW-1:0] pend_y;
    logic signed [CORDW:0]   x_new;
    logic                    accept, scan_hit, retire, alloc, free_found;
    logic [IDXW-1:0]         free_idx;
    logic [N_SPR-1:0]        en_nxt;

    assign accept   = (state == IDLE) && ctl.frame;
    assign busy     = (state != IDLE);
    assign scan_hit = (state == SCAN) && spr_en[idx];

    // NOTE: every always_comb assigns its outputs a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctl.frame)       state_nxt = SCAN;
            SCAN:    if (idx == LAST_IDX) state_nxt = SPAWN;
            SPAWN:                        state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // One bit wider than a coordinate so a sprite near the left edge cannot wrap.
    assign x_new  = {pos_x[idx][CORDW-1], pos_x[idx]} - {{(CORDW-3){1'b0}}, ctl.speed};
    assign retire = scan_hit && (x_new <= X_LIM);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (!spr_en[i]) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
        end
    end

    assign alloc = (state == SPAWN) && pend && free_found;

    always_comb begin
        en_nxt = spr_en;
        if (retire) en_nxt[idx]      = 1'b0;
        if (alloc)  en_nxt[free_idx] = 1'b1;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            spr_en         <= '0;
            active_cnt     <= '0;
            pend           <= 1'b0;
            pend_y         <= '0;
            ctl.spawn_ack  <= 1'b0;
            ctl.spawn_drop <= 1'b0;
            // NOTE: positions drive the engines directly, so the array is reset like any register.
            for (int i = 0; i < N_SPR; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            spr_en     <= en_nxt;
            active_cnt <= CNTW'($countones(en_nxt));

            if (accept)                                idx <= '0;
            else if (state == SCAN && idx != LAST_IDX) idx <= idx + 1'b1;

            if (scan_hit && !retire) pos_x[idx] <= x_new[CORDW-1:0];
            if (alloc) begin
                pos_x[free_idx] <= CORDW'(H_RES);
                pos_y[free_idx] <= pend_y;
            end

            ctl.spawn_ack  <= alloc;
            ctl.spawn_drop <= ctl.spawn_req && pend && !alloc;
            if (ctl.spawn_req && (!pend || alloc)) begin
                pend   <= 1'b1;
                pend_y <= ctl.spawn_y;
            end else if (alloc) begin
                pend <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_SPR; g++) begin : g_bus
        assign sprx_bus[g*CORDW +: CORDW] = pos_x[g];
        assign spry_bus[g*CORDW +: CORDW] = pos_y[g];
    end

    sprite_pix_mux #(
        .N_SPR     (N_SPR),
        .SPR_DATAW (SPR_DATAW)
    ) u_pix_mux (
        .clk            (clk),
        .rst            (rst),
        .spr_en         (spr_en),
        .spr_drawing    (spr_drawing),
        .spr_pix        (spr_pix),
        .player_drawing (player_drawing),
        .hit_clr        (accept),
        .pix_out        (pix_out),
        .drawing_out    (drawing_out),
        .hit            (hit)
    );

endmodule
